servo_input_decoder: RTL and testbench



---
 rtl/servo_input_decoder.sv | 166 ++++++++++++++++
 tb/tb_servo_input_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/servo_input_decoder.sv
// Servo pulse receiver: measures the high time of a ~50 Hz servo pulse train,
// validates it and maps it back to a 0..TIMER_MAX value with lock/loss status.
module servo_input_decoder #(
    parameter int MIN_PULSE_CYCLES = 700,
    parameter int MAX_PULSE_CYCLES = 2300,
    parameter int TIMER_MAX        = 60,
    parameter int TOL_CYCLES       = 100,
    parameter int TIMEOUT_CYCLES   = 25000,
    parameter int LOCK_COUNT       = 3
) (
    input  logic        clk_1mhz,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [6:0]  timer_out,
    output logic [12:0] pulse_width,
    output logic        timer_valid,
    output logic        err_pulse,
    output logic        locked,
    output logic        signal_lost
);

    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW    = $clog2(LOCK_COUNT + 1);
    localparam int RANGE = MAX_PULSE_CYCLES - MIN_PULSE_CYCLES;

    localparam logic [12:0]   W_MIN     = 13'(MIN_PULSE_CYCLES);
    localparam logic [12:0]   W_MAX     = 13'(MAX_PULSE_CYCLES);
    localparam logic [12:0]   W_LO      = 13'(MIN_PULSE_CYCLES - TOL_CYCLES);
    localparam logic [12:0]   W_HI      = 13'(MAX_PULSE_CYCLES + TOL_CYCLES);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_COUNT);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {S_ARM, S_WAIT_RISE, S_HIGH, S_EVAL} state_t;

    state_t        r_state, w_nextState;
    logic          r_sync1, r_sync2, r_prev;
    logic [1:0]    r_fill;
    logic [12:0]   r_widthCnt;
    logic [TW-1:0] r_toCnt;
    logic [GW-1:0] r_goodCnt;
    logic [6:0]    r_timer;
    logic [12:0]   r_width;
    logic          r_valid, r_err, r_locked, r_lost;

    logic          w_rise, w_fall, w_start, w_inc, w_overErr, w_eval;
    logic          w_accept, w_reject, w_toReach;
    logic [12:0]   w_clamped;
    logic [16:0]   w_scaled;
    logic [6:0]    w_timer;

    assign w_rise    = r_sync2 & ~r_prev;
    assign w_fall    = ~r_sync2 & r_prev;
    assign w_accept  = w_eval && (r_widthCnt >= W_LO) && (r_widthCnt <= W_HI);
    assign w_reject  = w_eval && !w_accept;
    assign w_toReach = !w_rise && (r_toCnt == TO_LAST);

    // Clamp then scale with round-to-nearest so every generator width maps back exactly
    assign w_clamped = (r_widthCnt < W_MIN) ? W_MIN : (r_widthCnt > W_MAX) ? W_MAX : r_widthCnt;
    assign w_scaled  = 17'(w_clamped - W_MIN) * 17'(TIMER_MAX) + 17'(RANGE / 2);
    assign w_timer   = 7'(w_scaled / 17'(RANGE));

    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) r_state <= S_ARM;
        else        r_state <= w_nextState;
    end

    // The sync flops leave reset at 0, so S_ARM waits until they hold real samples
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_inc       = 1'b0;
        w_overErr   = 1'b0;
        w_eval      = 1'b0;
        unique case (r_state)
            S_ARM: begin
                if (r_fill[1] && !r_sync2) w_nextState = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (w_rise) begin
                    w_start     = 1'b1;
                    w_nextState = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    w_nextState = S_EVAL;
                end else if (r_sync2) begin
                    if (r_widthCnt == W_HI) begin
                        w_overErr   = 1'b1;
                        w_nextState = S_ARM;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            S_EVAL: begin
                w_eval      = 1'b1;
                w_nextState = S_WAIT_RISE;
            end
            default: w_nextState = S_ARM;
        endcase
    end

    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_prev     <= 1'b0;
            r_fill     <= 2'b00;
            r_widthCnt <= '0;
            r_toCnt    <= '0;
            r_goodCnt  <= '0;
            r_timer    <= '0;
            r_width    <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_locked   <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_fill  <= {r_fill[0], 1'b1};
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            if (w_start)    r_widthCnt <= 13'd1;
            else if (w_inc) r_widthCnt <= r_widthCnt + 13'd1;

            if (w_rise)                 r_toCnt <= '0;
            else if (r_toCnt != TO_MAX) r_toCnt <= r_toCnt + 1'b1;

            if (w_toReach) begin
                r_lost    <= 1'b1;
                r_locked  <= 1'b0;
                r_goodCnt <= '0;
            end

            if (w_overErr || w_reject) begin
                r_err     <= 1'b1;
                r_goodCnt <= '0;
                r_locked  <= 1'b0;
            end

            // Acceptance comes last so it overrides a timeout in the same cycle
            if (w_accept) begin
                r_timer <= w_timer;
                r_width <= r_widthCnt;
                r_valid <= 1'b1;
                r_lost  <= 1'b0;
                if (r_goodCnt != GOOD_MAX) r_goodCnt <= r_goodCnt + 1'b1;
                if (r_goodCnt >= GOOD_LAST) r_locked <= 1'b1;
            end
        end
    end

    assign timer_out   = r_timer;
    assign pulse_width = r_width;
    assign timer_valid = r_valid;
    assign err_pulse   = r_err;
    assign locked      = r_locked;
    assign signal_lost = r_lost;

endmodule

// File: tb/tb_servo_input_decoder.sv
// Scoreboard bench for servo_input_decoder: drives pulses, queues expected
// decode results and compares them when the DUT strobes.
module tb_servo_input_decoder;

    localparam int TIMEOUT = 5000;
    localparam int GAP     = 200;

    logic        clk_1mhz = 1'b0;
    logic        rst_n    = 1'b0;
    logic        pwm_in   = 1'b0;
    logic [6:0]  timer_out;
    logic [12:0] pulse_width;
    logic        timer_valid, err_pulse, locked, signal_lost;

    servo_input_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_1mhz   (clk_1mhz),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .timer_out  (timer_out),
        .pulse_width(pulse_width),
        .timer_valid(timer_valid),
        .err_pulse  (err_pulse),
        .locked     (locked),
        .signal_lost(signal_lost)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    int cyc = 0;
    always @(posedge clk_1mhz) cyc <= cyc + 1;

    typedef struct {
        bit isErr;
        int timer;
        int width;
        bit lockd;
        bit lost;
        int cycle;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int lastTimer = 0;
    int lastWidth = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_timer"}, int'(timer_out), 0);
        checkOutput({tag, "_width"}, int'(pulse_width), 0);
        checkOutput({tag, "_valid"}, int'(timer_valid), 0);
        checkOutput({tag, "_err"},   int'(err_pulse), 0);
        checkOutput({tag, "_lock"},  int'(locked), 0);
        checkOutput({tag, "_lost"},  int'(signal_lost), 0);
    endtask

    task automatic pushExp(input bit isErr, input int timer, input int width,
                           input bit lockd, input bit lost, input int cycle);
        exp_t e;
        e.isErr = isErr;
        e.lockd = lockd;
        e.lost  = lost;
        e.cycle = cycle;
        if (isErr) begin
            e.timer = lastTimer;
            e.width = lastWidth;
        end else begin
            e.timer   = timer;
            e.width   = width;
            lastTimer = timer;
            lastWidth = width;
        end
        sb.push_back(e);
    endtask

    // One pulse of 'width' high samples followed by a low gap
    task automatic applyStimulus(input int width, input bit isErr, input int timer,
                                 input bit lockd, input bit lost);
        @(negedge clk_1mhz);
        pwm_in = 1'b1;
        repeat (width) @(negedge clk_1mhz);
        pushExp(isErr, timer, width, lockd, lost, cyc + 4);
        pwm_in = 1'b0;
        repeat (GAP) @(negedge clk_1mhz);
    endtask

    always @(negedge clk_1mhz) begin
        exp_t m;
        if (timer_valid || err_pulse) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_strobe", 1, 0);
            end else begin
                m = sb.pop_front();
                checkOutput("err_kind",  int'(err_pulse), int'(m.isErr));
                checkOutput("valid_kind", int'(timer_valid), int'(!m.isErr));
                checkOutput("timer_out", int'(timer_out), m.timer);
                checkOutput("pulse_width", int'(pulse_width), m.width);
                checkOutput("locked", int'(locked), int'(m.lockd));
                checkOutput("signal_lost", int'(signal_lost), int'(m.lost));
                if (m.cycle >= 0) checkOutput("latency", cyc, m.cycle);
            end
        end
    end

    initial begin
        int w;
        rst_n = 1'b0;
        repeat (5) @(negedge clk_1mhz);
        checkReset("reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk_1mhz);

        applyStimulus(700,  0, 0,  0, 0);
        applyStimulus(1500, 0, 30, 0, 0);
        applyStimulus(2300, 0, 60, 1, 0);

        for (int t = 0; t <= 60; t += 5) begin
            w = 1600 * t / 60 + 700;
            applyStimulus(w, 0, t, 1, 0);
        end
        applyStimulus(1600 * 1 / 60 + 700,  0, 1,  1, 0);
        applyStimulus(1600 * 59 / 60 + 700, 0, 59, 1, 0);

        applyStimulus(650,  0, 0,  1, 0);
        applyStimulus(600,  0, 0,  1, 0);
        applyStimulus(2400, 0, 60, 1, 0);
        applyStimulus(599,  1, 0,  0, 0);
        applyStimulus(500,  1, 0,  0, 0);

        applyStimulus(1200, 0, 19, 0, 0);
        applyStimulus(1200, 0, 19, 0, 0);
        applyStimulus(1200, 0, 19, 1, 0);

        // Stuck high: one overlong error, then loss
        @(negedge clk_1mhz);
        pwm_in = 1'b1;
        pushExp(1, 0, 0, 0, 0, cyc + 1 + 2402);
        for (int i = 0; i < TIMEOUT + 100 && signal_lost !== 1'b1; i++) @(negedge clk_1mhz);
        checkOutput("lost_stuck_high", int'(signal_lost), 1);
        checkOutput("lock_stuck_high", int'(locked), 0);
        checkOutput("timer_hold_high", int'(timer_out), 19);
        pwm_in = 1'b0;
        repeat (GAP) @(negedge clk_1mhz);
        applyStimulus(1500, 0, 30, 0, 0);
        applyStimulus(1500, 0, 30, 0, 0);
        applyStimulus(1500, 0, 30, 1, 0);

        // Stuck low: loss drops lock, timer holds
        for (int i = 0; i < TIMEOUT + 100 && signal_lost !== 1'b1; i++) @(negedge clk_1mhz);
        checkOutput("lost_stuck_low", int'(signal_lost), 1);
        checkOutput("lock_stuck_low", int'(locked), 0);
        checkOutput("timer_hold_low", int'(timer_out), 30);

        // Reset in the middle of a pulse, released while still high
        @(negedge clk_1mhz);
        pwm_in = 1'b1;
        repeat (300) @(negedge clk_1mhz);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_1mhz);
        checkReset("midreset");
        rst_n = 1'b1;
        lastTimer = 0;
        lastWidth = 0;
        repeat (1197) @(negedge clk_1mhz);
        pwm_in = 1'b0;
        repeat (GAP) @(negedge clk_1mhz);
        checkOutput("midreset_timer", int'(timer_out), 0);
        applyStimulus(1500, 0, 30, 0, 0);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk_1mhz);
        checkOutput("drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
